// File: rtl/fetch_stage.sv
// Instruction fetch: PC/request register, one-entry stall hold buffer,
// stale-response drop after redirect, and the IF/ID pipeline register.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        freeze,
    input  logic        branch_taken,
    input  logic [31:0] branch_address,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] id_pc,
    output logic [31:0] id_instr,
    output logic        id_valid
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_STALL = 2'd1,
        S_DROP  = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] req_addr_q, req_addr_d;
    logic [31:0] next_pc_q, next_pc_d;
    logic [31:0] hold_pc_q, hold_pc_d;
    logic [31:0] hold_instr_q, hold_instr_d;
    logic [31:0] id_pc_q, id_pc_d;
    logic [31:0] id_instr_q, id_instr_d;
    logic        id_valid_q, id_valid_d;
    logic [31:0] step_addr;

    assign step_addr = req_addr_q + PC_STEP;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_FETCH: begin
                if (branch_taken) begin
                    state_d = imem_ready ? S_FETCH : S_DROP;
                end else if (imem_ready && freeze) begin
                    state_d = S_STALL;
                end
            end
            S_STALL: begin
                if (branch_taken || !freeze) begin
                    state_d = S_FETCH;
                end
            end
            S_DROP: begin
                if (imem_ready) begin
                    state_d = S_FETCH;
                end
            end
            default: state_d = S_FETCH;
        endcase
    end

    always_comb begin
        imem_req  = (state_q != S_STALL);
        imem_addr = req_addr_q;
        id_pc     = id_pc_q;
        id_instr  = id_instr_q;
        id_valid  = id_valid_q;
    end

    always_comb begin
        req_addr_d   = req_addr_q;
        next_pc_d    = next_pc_q;
        hold_pc_d    = hold_pc_q;
        hold_instr_d = hold_instr_q;
        id_pc_d      = id_pc_q;
        id_instr_d   = id_instr_q;
        id_valid_d   = id_valid_q;
        unique case (state_q)
            S_FETCH: begin
                if (branch_taken) begin
                    id_valid_d = 1'b0;
                    next_pc_d  = branch_address;
                    if (imem_ready) begin
                        req_addr_d = branch_address;
                    end
                end else if (imem_ready && !freeze) begin
                    id_instr_d = imem_rdata;
                    id_pc_d    = step_addr;
                    id_valid_d = 1'b1;
                    req_addr_d = step_addr;
                    next_pc_d  = step_addr;
                end else if (imem_ready) begin
                    hold_instr_d = imem_rdata;
                    hold_pc_d    = step_addr;
                    next_pc_d    = step_addr;
                end else if (!freeze) begin
                    id_valid_d = 1'b0;
                end
            end
            S_STALL: begin
                if (branch_taken) begin
                    id_valid_d = 1'b0;
                    req_addr_d = branch_address;
                    next_pc_d  = branch_address;
                end else if (!freeze) begin
                    id_pc_d    = hold_pc_q;
                    id_instr_d = hold_instr_q;
                    id_valid_d = 1'b1;
                    req_addr_d = next_pc_q;
                end
            end
            S_DROP: begin
                // The response to the old address is still owed; swallow it.
                id_valid_d = 1'b0;
                if (branch_taken) begin
                    next_pc_d = branch_address;
                end
                if (imem_ready) begin
                    req_addr_d = branch_taken ? branch_address : next_pc_q;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            req_addr_q   <= RESET_PC;
            next_pc_q    <= RESET_PC;
            hold_pc_q    <= '0;
            hold_instr_q <= '0;
            id_pc_q      <= '0;
            id_instr_q   <= '0;
            id_valid_q   <= 1'b0;
        end else begin
            req_addr_q   <= req_addr_d;
            next_pc_q    <= next_pc_d;
            hold_pc_q    <= hold_pc_d;
            hold_instr_q <= hold_instr_d;
            id_pc_q      <= id_pc_d;
            id_instr_q   <= id_instr_d;
            id_valid_q   <= id_valid_d;
        end
    end

endmodule
